// File: rtl/alu_result_packer.sv
// Buffers 16-bit ALU results and serialises each into two bytes; first byte valid one cycle after capture.
// Bytes hold stable under TX_READY backpressure; a result arriving at a full FIFO is dropped and OVERRUN set.
module alu_result_packer #(
  parameter int DEPTH    = 4,
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ALU_OUT,
  input  logic        OUT_VALID,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_READY,
  output logic        BUSY,
  output logic        OVERRUN,
  input  logic        CLR_OVR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_B0, SEND_B1} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH:0]  count;
  logic [15:0]     hold_q, hold_d, head;
  logic [7:0]      data_d;
  logic            vld_d;
  logic            pop, push, drop, xfer;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return HI_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return HI_FIRST ? w[7:0] : w[15:8];
  endfunction

  assign head = mem[rd_ptr];
  assign xfer = TX_D_VLD && TX_READY;
  // A pop on this edge frees a slot, so a full FIFO can still accept.
  assign push = OUT_VALID && ((count < FULL_CNT) || pop);
  assign drop = OUT_VALID && !push;
  assign BUSY = (state_q != IDLE) || (count != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    hold_d  = hold_q;
    data_d  = TX_P_DATA;
    vld_d   = TX_D_VLD;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          hold_d  = head;
          data_d  = first_byte(head);
          vld_d   = 1'b1;
          state_d = SEND_B0;
        end
      end
      SEND_B0: begin
        if (xfer) begin
          data_d  = second_byte(hold_q);
          state_d = SEND_B1;
        end
      end
      SEND_B1: begin
        if (xfer) begin
          if (count != '0) begin
            pop     = 1'b1;
            hold_d  = head;
            data_d  = first_byte(head);
            state_d = SEND_B0;
          end else begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      TX_P_DATA <= data_d;
      TX_D_VLD  <= vld_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= ALU_OUT;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         OVERRUN <= 1'b0;
    else if (drop)    OVERRUN <= 1'b1;
    else if (CLR_OVR) OVERRUN <= 1'b0;
  end

endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: two instances (low-first and high-first) checked against a queue-based model.
module tb_alu_result_packer;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID, TX_READY, CLR_OVR;
  logic [7:0]  data_lo, data_hi;
  logic        vld_lo, vld_hi, busy_lo, busy_hi, ovr_lo, ovr_hi;

  always #5 CLK = ~CLK;

  alu_result_packer #(.DEPTH(DEPTH), .HI_FIRST(1'b0)) u_lo (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_P_DATA(data_lo), .TX_D_VLD(vld_lo), .TX_READY(TX_READY),
    .BUSY(busy_lo), .OVERRUN(ovr_lo), .CLR_OVR(CLR_OVR));

  alu_result_packer #(.DEPTH(DEPTH), .HI_FIRST(1'b1)) u_hi (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_P_DATA(data_hi), .TX_D_VLD(vld_hi), .TX_READY(TX_READY),
    .BUSY(busy_hi), .OVERRUN(ovr_hi), .CLR_OVR(CLR_OVR));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a word queue plus "which word is on the wire and which half".
  logic [15:0] m_q[$];
  logic [15:0] m_word;
  logic        m_vld, m_second, m_ovr;
  logic [7:0]  got_lo[$], got_hi[$];

  typedef struct {
    logic        ov;
    logic [15:0] d;
    logic        rdy;
    logic        clr;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic        exp_ovr;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_word   = '0;
    m_vld    = 1'b0;
    m_second = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_edge();
    int sz;
    bit popped, xfer;
    sz     = m_q.size();
    popped = 0;
    xfer   = m_vld && TX_READY;
    if (!m_vld) begin
      if (sz > 0) begin
        m_word = m_q.pop_front(); m_vld = 1'b1; m_second = 1'b0; popped = 1;
      end
    end else if (xfer) begin
      if (!m_second) m_second = 1'b1;
      else if (sz > 0) begin
        m_word = m_q.pop_front(); m_second = 1'b0; popped = 1;
      end else m_vld = 1'b0;
    end
    if (OUT_VALID) begin
      if (sz < DEPTH || popped) m_q.push_back(ALU_OUT);
      else m_ovr = 1'b1;
    end else if (CLR_OVR) m_ovr = 1'b0;
    if (OUT_VALID && !(sz < DEPTH || popped)) m_ovr = 1'b1;
    else if (OUT_VALID && CLR_OVR) m_ovr = 1'b0;
  endtask

  task automatic compare();
    logic busy_exp;
    busy_exp = m_vld || (m_q.size() > 0);
    check("vld_lo", vld_lo, m_vld);
    check("vld_hi", vld_hi, m_vld);
    if (m_vld) begin
      check("data_lo", data_lo, m_second ? m_word[15:8] : m_word[7:0]);
      check("data_hi", data_hi, m_second ? m_word[7:0] : m_word[15:8]);
    end
    check("busy_lo", busy_lo, busy_exp);
    check("busy_hi", busy_hi, busy_exp);
    check("ovr_lo", ovr_lo, m_ovr);
    check("ovr_hi", ovr_hi, m_ovr);
  endtask

  // Called at a negedge: drive inputs, clock one edge, compare at the next negedge.
  task automatic step(input logic ov, input logic [15:0] d, input logic rdy, input logic clr);
    OUT_VALID = ov; ALU_OUT = d; TX_READY = rdy; CLR_OVR = clr;
    if (vld_lo && rdy) got_lo.push_back(data_lo);
    if (vld_hi && rdy) got_hi.push_back(data_hi);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_reset();
    #1;
    compare();
    check("rst_data_lo", data_lo, 16'h0);
    check("rst_data_hi", data_hi, 16'h0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  vec_t tbl[13];

  initial begin
    logic [7:0] exp_b[$];
    int first, last;

    OUT_VALID = 1'b0; ALU_OUT = '0; TX_READY = 1'b0; CLR_OVR = 1'b0;
    do_reset();

    // Single word, then backpressured word (low-first instance expectations)
    tbl[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ov, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_vld", i), vld_lo, tbl[i].exp_vld);
      if (tbl[i].exp_vld) check($sformatf("tbl%0d_data", i), data_lo, tbl[i].exp_data);
      check($sformatf("tbl%0d_busy", i), busy_lo, tbl[i].exp_busy);
      check($sformatf("tbl%0d_ovr", i), ovr_lo, tbl[i].exp_ovr);
    end

    // Overflow: five consecutive results all fit (one popped into the holding register)
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    check("ovf_no_drop_yet", ovr_lo, 16'h0);
    // Sixth is dropped; a same-edge clear loses to the set
    step(1'b1, 16'h0006, 1'b0, 1'b1);
    check("ovf_set_wins", ovr_lo, 16'h1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("ovf_cleared", ovr_lo, 16'h0);
    got_lo.delete(); got_hi.delete();
    for (int i = 0; i < 14; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    exp_b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
    check("ovf_byte_count", 16'(got_lo.size()), 16'd10);
    for (int i = 0; i < 10 && i < got_lo.size(); i++)
      check($sformatf("ovf_byte%0d", i), got_lo[i], exp_b[i]);

    // Back-to-back, high-first instance: six contiguous bytes
    got_hi.delete();
    first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) step(1'b1, 16'hAB01 + 16'(c) * 16'h2201, 1'b1, 1'b0);
      else       step(1'b0, 16'h0000, 1'b1, 1'b0);
      if (vld_hi) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    check("b2b_span", 16'(last - first + 1), 16'd6);
    exp_b = '{8'hAB, 8'h01, 8'hCD, 8'h02, 8'hEF, 8'h03};
    check("b2b_count", 16'(got_hi.size()), 16'd6);
    for (int i = 0; i < 6 && i < got_hi.size(); i++)
      check($sformatf("b2b_byte%0d", i), got_hi[i], exp_b[i]);

    // Reset while the second byte is out and two words wait
    for (int c = 0; c < 3; c++) step(1'b1, 16'h5000 + 16'(c), 1'b1, 1'b0);
    check("pre_rst_vld", vld_lo, 16'h1);
    check("pre_rst_busy", busy_lo, 16'h1);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("post_rst_vld", vld_lo, 16'h0);
      check("post_rst_busy", busy_lo, 16'h0);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
